// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR AXI burst master.
// Contents: FSM state encoding, AXI burst/response/lock constants and the
// beat-size helper used to derive asize from the data width.
package ddr_axi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BRESP = 3'd3,
    RDATA = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;

  // AXI size encoding: log2 of bytes per beat (4 for 128-bit, 5 for 256-bit).
  function automatic logic [2:0] asize_from_dw(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/ddr_beat_counter.sv
// Beat counter shared by the write and read data phases.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clr       - zero the count (command capture)
//   inc       - one data handshake completed
//   len       - burst length minus one
//   last_c    - current beat is the final one (combinational)
module ddr_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       last_c
);

  logic [7:0] count;

  // 8-bit count is enough: the compare against len=255 fires before any wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign last_c = (count == len);

endmodule

// File: rtl/ddr_burst_master.sv
// Single-outstanding INCR burst initiator for the combined-address-channel
// DDR AXI port. A command (write/read, address, length) is captured in IDLE,
// issued on the A channel, then data is passed straight through between the
// local streams and the W/R channels until the last beat; writes finish on B.
// Ports:
//   mem_clk, reset                 - clock, asynchronous active-high reset
//   cmd_*                          - command request/accept
//   wr_* / rd_*                    - local write source / read sink streams
//   a*_0, w*_0, r*_0, b*_0         - DDR AXI port (initiator side)
//   done                           - one-cycle pulse when a burst completes
//   err                            - sticky error (ID/response/rlast mismatch)
// Build option: define DDR_MASTER_TIMEOUT_EN to add a response watchdog that
// abandons a stalled burst after TIMEOUT_CYC idle cycles and flags err.
module ddr_burst_master
  import ddr_axi_pkg::*;
#(
  parameter int unsigned DW          = 128,
  parameter int unsigned AW          = 32,
  parameter logic [7:0]  MASTER_ID   = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            mem_clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_strb,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [7:0]      aid_0,
  output logic [31:0]     aaddr_0,
  output logic [7:0]      alen_0,
  output logic [2:0]      asize_0,
  output logic [1:0]      aburst_0,
  output logic [1:0]      alock_0,
  output logic            avalid_0,
  input  logic            aready_0,
  output logic            atype_0,
  output logic [7:0]      wid_0,
  output logic [DW-1:0]   wdata_0,
  output logic [DW/8-1:0] wstrb_0,
  output logic            wlast_0,
  output logic            wvalid_0,
  input  logic            wready_0,
  input  logic [7:0]      rid_0,
  input  logic [DW-1:0]   rdata_0,
  input  logic            rlast_0,
  input  logic            rvalid_0,
  output logic            rready_0,
  input  logic [1:0]      rresp_0,
  input  logic [7:0]      bid_0,
  input  logic            bvalid_0,
  output logic            bready_0,
  output logic            done,
  output logic            err
);

  localparam logic [2:0]  ASIZE     = asize_from_dw(DW);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << ASIZE) - 32'd1);

  // Elaboration-time parameter sanity.
  if (!(DW == 128 || DW == 256)) begin : g_bad_dw
    $error("ddr_burst_master: DW must be 128 or 256");
  end
  if (AW > 32 || AW == 0) begin : g_bad_aw
    $error("ddr_burst_master: AW must be 1..32");
  end
  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
    $error("ddr_burst_master: TIMEOUT_CYC must fit the 16-bit watchdog");
  end

  state_t state, state_d;

  logic cap_cmd, cnt_clr, cnt_inc, cnt_last;
  logic done_d, err_d, cmd_ready_d, avalid_d, bready_d;
  logic a_hs, w_hs, b_hs, r_hs;
  logic tmo_hit;

  // Constant A/W channel fields.
  assign aid_0    = MASTER_ID;
  assign wid_0    = MASTER_ID;
  assign asize_0  = ASIZE;
  assign aburst_0 = AXI_BURST_INCR;
  assign alock_0  = AXI_LOCK_NORMAL;

  // Data buses pass through; only the valid/ready pair is gated by state.
  assign wdata_0 = wr_data;
  assign wstrb_0 = wr_strb;
  assign rd_data = rdata_0;

  assign a_hs = (state == ADDR)  && avalid_0 && aready_0;
  assign w_hs = (state == WDATA) && wr_valid && wready_0;
  assign b_hs = (state == BRESP) && bvalid_0 && bready_0;
  assign r_hs = (state == RDATA) && rvalid_0 && rd_ready;

  ddr_beat_counter u_beat_counter (
    .clk    (mem_clk),
    .rst    (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .len    (alen_0),
    .last_c (cnt_last)
  );

`ifdef DDR_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        hs_any;

  assign hs_any  = a_hs || w_hs || b_hs || r_hs;
  assign tmo_hit = (state != IDLE) && (tmo_cnt == 16'(TIMEOUT_CYC));

  // Watchdog restarts on every state change and every handshake.
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || state_d != state || hs_any) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, pass-through handshakes and next values of registered outputs.
  always_comb begin
    state_d  = state;
    cap_cmd  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    done_d   = 1'b0;
    err_d    = err;
    wvalid_0 = 1'b0;
    wr_ready = 1'b0;
    wlast_0  = 1'b0;
    rd_valid = 1'b0;
    rready_0 = 1'b0;
    rd_last  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cap_cmd = 1'b1;
          cnt_clr = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (a_hs) begin
          state_d = atype_0 ? WDATA : RDATA;
        end
      end
      WDATA: begin
        wvalid_0 = wr_valid;
        wr_ready = wready_0;
        wlast_0  = cnt_last;
        if (w_hs) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = BRESP;
          end
        end
      end
      BRESP: begin
        if (b_hs) begin
          if (bid_0 != MASTER_ID) begin
            err_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RDATA: begin
        rd_valid = rvalid_0;
        rready_0 = rd_ready;
        rd_last  = cnt_last;
        if (r_hs) begin
          cnt_inc = 1'b1;
          if (rresp_0 != AXI_RESP_OKAY || rid_0 != MASTER_ID || rlast_0 != cnt_last) begin
            err_d = 1'b1;
          end
          // Completion follows our own count; a bad rlast_0 only flags err.
          if (cnt_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon a stalled burst: no done pulse, all handshakes dropped.
    if (tmo_hit) begin
      state_d  = IDLE;
      err_d    = 1'b1;
      done_d   = 1'b0;
      cnt_inc  = 1'b0;
      wvalid_0 = 1'b0;
      wr_ready = 1'b0;
      rd_valid = 1'b0;
      rready_0 = 1'b0;
    end

    cmd_ready_d = (state_d == IDLE);
    avalid_d    = (state_d == ADDR);
    bready_d    = (state_d == BRESP);
  end

  // Registered outputs and captured command.
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      cmd_ready <= 1'b0;
      avalid_0  <= 1'b0;
      bready_0  <= 1'b0;
      aaddr_0   <= '0;
      alen_0    <= '0;
      atype_0   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      avalid_0  <= avalid_d;
      bready_0  <= bready_d;
      done      <= done_d;
      err       <= err_d;
      if (cap_cmd) begin
        aaddr_0 <= 32'(cmd_addr) & ADDR_MASK;
        alen_0  <= cmd_len;
        atype_0 <= cmd_write;
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_master.sv
// Self-checking bench for ddr_burst_master: directed table of bursts, two
// hand-written corner sequences, then randomized bursts checked against a
// word-addressed memory model of what the local side wrote.
`timescale 1ns/1ps
module tb_ddr_burst_master;

  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 32;
  localparam int unsigned NB  = DW / 8;
  localparam logic [7:0]  MID = 8'h5A;
  localparam int unsigned TMO = 64;

  logic            mem_clk, reset;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [DW-1:0]   wr_data;
  logic [NB-1:0]   wr_strb;
  logic            wr_valid, wr_ready;
  logic [DW-1:0]   rd_data;
  logic            rd_last, rd_valid, rd_ready;
  logic [7:0]      aid_0, alen_0, wid_0, rid_0, bid_0;
  logic [31:0]     aaddr_0;
  logic [2:0]      asize_0;
  logic [1:0]      aburst_0, alock_0, rresp_0;
  logic            avalid_0, aready_0, atype_0;
  logic [DW-1:0]   wdata_0, rdata_0;
  logic [NB-1:0]   wstrb_0;
  logic            wlast_0, wvalid_0, wready_0;
  logic            rlast_0, rvalid_0, rready_0;
  logic            bvalid_0, bready_0;
  logic            done, err;

  ddr_burst_master #(
    .DW(DW), .AW(AW), .MASTER_ID(MID), .TIMEOUT_CYC(TMO)
  ) dut (
    .mem_clk(mem_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .aid_0(aid_0), .aaddr_0(aaddr_0), .alen_0(alen_0), .asize_0(asize_0),
    .aburst_0(aburst_0), .alock_0(alock_0), .avalid_0(avalid_0), .aready_0(aready_0),
    .atype_0(atype_0), .wid_0(wid_0), .wdata_0(wdata_0), .wstrb_0(wstrb_0),
    .wlast_0(wlast_0), .wvalid_0(wvalid_0), .wready_0(wready_0),
    .rid_0(rid_0), .rdata_0(rdata_0), .rlast_0(rlast_0), .rvalid_0(rvalid_0),
    .rready_0(rready_0), .rresp_0(rresp_0),
    .bid_0(bid_0), .bvalid_0(bvalid_0), .bready_0(bready_0),
    .done(done), .err(err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int errors = 0;

  // Reference: what the local side wrote, indexed by 16-byte beat address.
  logic [DW-1:0] model_mem [int];
  // Responder storage, filled from what the DUT put on the W channel.
  logic [DW-1:0] resp_mem [int];

  function automatic void chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    aready_0 = 1'b0; wready_0 = 1'b0; rid_0 = MID; rdata_0 = '0;
    rlast_0 = 1'b0; rvalid_0 = 1'b0; rresp_0 = 2'b00; bid_0 = MID; bvalid_0 = 1'b0;
  endtask

  // One complete burst with the bench acting as local source/sink and responder.
  // bp: 0 = no stalls, 1 = wr_valid every other cycle and rd_ready low 5 cycles,
  //     2 = random stalls everywhere.
  // inj: 0 none, 1 SLVERR on read beat 1, 2 wrong bid, 3 wrong rlast on read beat 0.
  task automatic run_burst(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input int bp, input int inj, input logic [31:0] exp_aaddr,
                           input bit exp_err);
    logic [DW-1:0] wd [$];
    logic [NB-1:0] ws [$];
    int  n, base, resp_base, wi, ri, cyc, dones, av_extra, rd_hold, b_wait, b_delay;
    bit  accepted, chk_av, a_done, data_done, b_done, fin, fin_seen;
    bit  in_data, a_before, fin_before;

    n = int'(len) + 1;
    base = int'(addr >> 4);
    resp_base = 0; wi = 0; ri = 0; cyc = 0; dones = 0; av_extra = 0;
    rd_hold = 0; b_wait = 0; b_delay = int'($urandom_range(0, 3));
    accepted = 0; chk_av = 0; a_done = 0; data_done = 0; b_done = 0;
    fin = 0; fin_seen = 0;
    for (int i = 0; i < n; i++) begin
      wd.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      ws.push_back(16'($urandom()));
    end

    while (!fin_seen && cyc < 20000) begin
      @(negedge mem_clk);
      cyc++;
      cmd_valid = !accepted; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      aready_0  = (bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid  = !data_done && ((bp == 0) || (bp == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1))));
      wr_data   = wd[(wi < n) ? wi : 0];
      wr_strb   = ws[(wi < n) ? wi : 0];
      wready_0  = (bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid_0  = a_done && !wr && !data_done && ((bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      rdata_0   = resp_mem.exists(resp_base + ri) ? resp_mem[resp_base + ri] : '0;
      rid_0     = MID;
      rlast_0   = (ri == n - 1);
      rresp_0   = 2'b00;
      if (inj == 1 && ri == 1) rresp_0 = 2'b10;
      if (inj == 3 && ri == 0) rlast_0 = ~rlast_0;
      rd_ready  = (bp == 1) ? (rd_hold >= 5) : ((bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      bvalid_0  = wr && data_done && !b_done && (b_wait >= b_delay);
      bid_0     = (inj == 2) ? ~MID : MID;
      #1;
      a_before   = a_done;
      fin_before = fin;
      in_data    = a_done && !data_done;
      if (done) dones++;

      if (chk_av) begin
        chk1("avalid_latency", avalid_0, 1'b1);
        chk_av = 0;
      end
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1; chk_av = 1;
      end
      if (a_before && avalid_0) av_extra++;
      if (!a_done && avalid_0 && aready_0) begin
        chkw("aaddr", 128'(aaddr_0), 128'(exp_aaddr));
        chkw("alen", 128'(alen_0), 128'(len));
        chk1("atype", atype_0, wr);
        resp_base = int'(aaddr_0 >> 4);
        a_done = 1;
      end

      if (wr && in_data) begin
        chk1("wvalid_track", wvalid_0, wr_valid);
        chk1("wr_ready_track", wr_ready, wready_0);
        if (wr_valid && wready_0) begin
          chkw("wdata", wdata_0, wd[wi]);
          chkw("wstrb", 128'(wstrb_0), 128'(ws[wi]));
          chk1("wlast", wlast_0, wi == n - 1);
          resp_mem[resp_base + wi] = wdata_0;
          model_mem[base + wi] = wd[wi];
          wi++;
          if (wi == n) data_done = 1;
        end
      end

      if (!wr && in_data) begin
        chk1("rd_valid_track", rd_valid, rvalid_0);
        chk1("rready_track", rready_0, rd_ready);
        if (rvalid_0 && rd_ready) begin
          chkw("rd_data", rd_data, model_mem.exists(base + ri) ? model_mem[base + ri] : '0);
          chk1("rd_last", rd_last, ri == n - 1);
          ri++;
          if (ri == n) begin data_done = 1; fin = 1; end
        end
        rd_hold++;
      end

      if (wr && data_done && !b_done && !in_data) begin
        b_wait++;
        if (bvalid_0) begin
          chk1("bready", bready_0, 1'b1);
          b_done = 1; fin = 1;
        end
      end

      if (fin_before) begin
        chk1("done_pulse", done, 1'b1);
        chk1("cmd_ready_after", cmd_ready, 1'b1);
        chk1("err", err, exp_err);
        fin_seen = 1;
      end
    end

    if (!fin_seen) begin
      checks++; errors++;
      $display("FAIL burst_timeout: burst at %0h len %0d did not finish in %0d cycles", addr, len, cyc);
    end else begin
      chki("done_count", dones, 1);
      chki("avalid_extra", av_extra, 0);
    end
    idle_inputs();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    int          bp;
    int          inj;
    logic [31:0] exp_aaddr;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int wb;
    bit acc;
    logic [31:0] ra;
    logic [7:0]  rl;
    bit          rw;

    vecs[0]  = '{1'b1, 32'h0000_0100, 8'd3,   0, 0, 32'h0000_0100, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 8'd3,   0, 0, 32'h0000_0100, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0200, 8'd5,   1, 0, 32'h0000_0200, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0200, 8'd5,   1, 0, 32'h0000_0200, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_010F, 8'd0,   0, 0, 32'h0000_0100, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_010F, 8'd0,   0, 0, 32'h0000_0100, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_1008, 8'd255, 2, 0, 32'h8000_1000, 1'b0};
    vecs[7]  = '{1'b0, 32'h8000_1000, 8'd255, 2, 0, 32'h8000_1000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0100, 8'd3,   0, 1, 32'h0000_0100, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0300, 8'd1,   0, 0, 32'h0000_0300, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0300, 8'd1,   0, 2, 32'h0000_0300, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0300, 8'd1,   0, 3, 32'h0000_0300, 1'b1};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge mem_clk);
    #1;
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_avalid", avalid_0, 1'b0);
    chk1("rst_bready", bready_0, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chkw("rst_aaddr", 128'(aaddr_0), 128'(0));
    chkw("rst_alen", 128'(alen_0), 128'(0));
    chkw("asize", 128'(asize_0), 128'(4));
    chkw("aburst", 128'(aburst_0), 128'(1));
    chkw("alock", 128'(alock_0), 128'(0));
    chkw("aid", 128'(aid_0), 128'(MID));
    chkw("wid", 128'(wid_0), 128'(MID));
    @(negedge mem_clk);
    reset = 1'b0;
    repeat (2) @(negedge mem_clk);

    for (int i = 0; i < 12; i++) begin
      run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].bp, vecs[i].inj,
                vecs[i].exp_aaddr, vecs[i].exp_err);
    end

    // Reset in the middle of an 8-beat write after 2 beats.
    wb = 0; acc = 0;
    for (int c = 0; c < 50 && wb < 2; c++) begin
      @(negedge mem_clk);
      cmd_valid = !acc; cmd_write = 1'b1; cmd_addr = 32'h0000_0400; cmd_len = 8'd7;
      aready_0 = 1'b1; wready_0 = 1'b1; wr_valid = 1'b1;
      wr_data = {$urandom(), $urandom(), $urandom(), $urandom()}; wr_strb = '1;
      #1;
      if (cmd_valid && cmd_ready) acc = 1;
      if (wvalid_0 && wready_0) wb++;
    end
    chki("rst_mid_beats", wb, 2);
    @(negedge mem_clk);
    #1;
    chk1("pre_rst_wvalid", wvalid_0, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rst_mid_wvalid", wvalid_0, 1'b0);
    chk1("rst_mid_wr_ready", wr_ready, 1'b0);
    chk1("rst_mid_avalid", avalid_0, 1'b0);
    chk1("rst_mid_rd_valid", rd_valid, 1'b0);
    chk1("rst_mid_err", err, 1'b0);
    idle_inputs();
    @(negedge mem_clk);
    reset = 1'b0;
    @(negedge mem_clk);
    #1;
    chk1("rst_rel_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_rel_done", done, 1'b0);

    // Randomized bursts in a small window so reads revisit earlier writes.
    for (int k = 0; k < 24; k++) begin
      ra = 32'($urandom_range(0, 32'h3FF));
      rl = 8'($urandom_range(0, 15));
      rw = 1'($urandom_range(0, 1));
      run_burst(rw, ra, rl, 2, 0, ra & 32'hFFFF_FFF0, 1'b0);
    end

`ifdef DDR_MASTER_TIMEOUT_EN
    // Write whose B response never arrives must be abandoned by the watchdog.
    begin
      int dn, cy;
      bit back;
      dn = 0; cy = 0; acc = 0; back = 0;
      while (!back && cy < int'(TMO) + 60) begin
        @(negedge mem_clk);
        cy++;
        cmd_valid = !acc; cmd_write = 1'b1; cmd_addr = 32'h0000_0500; cmd_len = 8'd0;
        aready_0 = 1'b1; wready_0 = 1'b1; wr_valid = 1'b1; bvalid_0 = 1'b0;
        #1;
        if (done) dn++;
        if (acc && cmd_ready) back = 1;
        if (cmd_valid && cmd_ready) acc = 1;
      end
      chk1("tmo_returned", back, 1'b1);
      chk1("tmo_err", err, 1'b1);
      chki("tmo_done", dn, 0);
      chk1("tmo_late", cy > int'(TMO), 1'b1);
      idle_inputs();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
